// File: rtl/wb_openram_multibank.sv
// -----------------------------------------------------------------------------
// wb_openram_multibank
//
// Wishbone B4 classic slave that fronts NUM_BANKS OpenRAM sky130 1RW macros
// (port 0). A base-addressed window is decoded into a bank select and a word
// address; the bridge then issues one macro command (chip select, write
// enable, byte mask) and acknowledges after a fixed, programmable latency.
//
// Parameters
//   NUM_BANKS   number of macros (1..8, any value)
//   ADDR_WIDTH  word-address bits per macro
//   BASE_ADDR   byte base of the window, aligned to the window size
//   READ_WAIT   extra cycles between the macro command and the data sample (0..7)
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_*_i / wbs_*_o       Wishbone slave (stb, cyc, we, sel, dat, adr / ack, err, dat)
//   ram_clk0                macro clock (same net as wb_clk_i)
//   ram_csb0[NUM_BANKS]     per-bank chip select, active low
//   ram_web0, ram_wmask0    shared write enable (active low) and byte mask
//   ram_addr0, ram_dout0    shared word address and write data
//   ram_din0                read data, bank b on [32*b+31:32*b]
//
// Optional feature: define WB_OPENRAM_ERR_EN to answer out-of-range requests
// with wbs_err_o instead of a zero-data acknowledge.
// -----------------------------------------------------------------------------
module wb_openram_multibank #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned READ_WAIT  = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      ram_clk0,
    output logic [NUM_BANKS-1:0]      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_dout0,
    input  logic [32*NUM_BANKS-1:0]   ram_din0
);

    localparam int unsigned BB     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned TOP_LO = ADDR_WIDTH + BB + 2;
    localparam logic [BB:0] NUM_BANKS_W = NUM_BANKS[BB:0];
    // Counter preload so that WAIT lasts exactly READ_WAIT cycles.
    localparam logic [2:0]  WAIT_INIT = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_ACK
    } state_e;

    state_e                state_q, state_d;
    logic [BB-1:0]         bank_q, bank_d;
    logic                  we_q, we_d;
    logic [2:0]            wait_q, wait_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_o_q, dat_o_d;
    logic [NUM_BANKS-1:0]  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           dout_q, dout_d;
`ifdef WB_OPENRAM_ERR_EN
    logic                  err_q, err_d;
`endif

    // Request decode. The two byte-lane address bits play no part in it.
    logic [ADDR_WIDTH-1:0] req_word;
    logic [BB-1:0]         req_bank;
    logic                  req_in_range;
    logic                  unused_adr;

    assign req_word     = wbs_adr_i[ADDR_WIDTH+1:2];
    assign req_bank     = wbs_adr_i[TOP_LO-1:ADDR_WIDTH+2];
    assign req_in_range = (wbs_adr_i[31:TOP_LO] == BASE_ADDR[31:TOP_LO]) &&
                          ({1'b0, req_bank} < NUM_BANKS_W);
    assign unused_adr   = ^wbs_adr_i[1:0];

    // Read-data mux over the macro outputs, steered by the latched bank.
    logic [31:0] rd_data;

    // NOTE: every signal written in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BB'(b)) rd_data = ram_din0[32*b +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        we_d    = we_q;
        wait_d  = wait_q;
        ack_d   = 1'b0;
        dat_o_d = dat_o_q;
        // Macro control is a one-cycle command pulse; address and data hold.
        csb_d   = '1;
        web_d   = 1'b1;
        wmask_d = '0;
        addr_d  = addr_q;
        dout_d  = dout_q;
`ifdef WB_OPENRAM_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (req_in_range) begin
                        state_d = S_CMD;
                        bank_d  = req_bank;
                        we_d    = wbs_we_i;
                        addr_d  = req_word;
                        dout_d  = wbs_dat_i;
                        web_d   = ~wbs_we_i;
                        wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                        for (int b = 0; b < NUM_BANKS; b++) begin
                            csb_d[b] = (req_bank != BB'(b));
                        end
                    end else begin
                        // Out of range: no macro access, answer in cycle 1.
                        state_d = S_ACK;
`ifdef WB_OPENRAM_ERR_EN
                        err_d   = 1'b1;
`else
                        ack_d   = 1'b1;
                        dat_o_d = '0;
`endif
                    end
                end
            end
            S_CMD: begin
                if (!wbs_cyc_i) begin
                    // Master gave up; the command already on the macro stands.
                    state_d = S_IDLE;
                end else if (we_q || READ_WAIT == 0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (!we_q) dat_o_d = rd_data;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dat_o_d = rd_data;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_ACK: begin
                // Guarantees at least one IDLE cycle between accesses.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
`ifdef WB_OPENRAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
`ifdef WB_OPENRAM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_o_q;
`ifdef WB_OPENRAM_ERR_EN
    assign wbs_err_o  = err_q;
`else
    assign wbs_err_o  = 1'b0;
`endif
    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = csb_q;
    assign ram_web0   = web_q;
    assign ram_wmask0 = wmask_q;
    assign ram_addr0  = addr_q;
    assign ram_dout0  = dout_q;

endmodule

// File: tb/tb_wb_openram_multibank.sv
// -----------------------------------------------------------------------------
// tb_wb_openram_multibank
//
// Two bridges (READ_WAIT = 1 and READ_WAIT = 3) run the same Wishbone
// transactions side by side, each against its own behavioural macro array.
// Expected data, cycle latencies, chip selects and error responses come from
// a flat word-array reference of the address window.
// -----------------------------------------------------------------------------
module tb_wb_openram_multibank;

    localparam int          NB   = 4;
    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          RW_A = 1;
    localparam int          RW_B = 3;
`ifdef WB_OPENRAM_ERR_EN
    localparam bit          ERR_EN = 1'b1;
`else
    localparam bit          ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc_a, stb_a, cyc_b, stb_b;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;

    logic        ack_a, err_a, ack_b, err_b;
    logic [31:0] dat_a, dat_b;
    logic        rclk_a, rclk_b;
    logic [3:0]  csb_a, csb_b, wm_a, wm_b;
    logic        web_a, web_b;
    logic [7:0]  ma_a, ma_b;
    logic [31:0] md_a, md_b;
    logic [127:0] din_a, din_b;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [NB*256];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    wb_openram_multibank #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_WAIT(RW_A)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb_a), .wbs_cyc_i(cyc_a), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack_a), .wbs_err_o(err_a), .wbs_dat_o(dat_a),
        .ram_clk0(rclk_a), .ram_csb0(csb_a), .ram_web0(web_a), .ram_wmask0(wm_a),
        .ram_addr0(ma_a), .ram_dout0(md_a), .ram_din0(din_a)
    );

    wb_openram_multibank #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_WAIT(RW_B)) u_dut_w3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb_b), .wbs_cyc_i(cyc_b), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack_b), .wbs_err_o(err_b), .wbs_dat_o(dat_b),
        .ram_clk0(rclk_b), .ram_csb0(csb_b), .ram_web0(web_b), .ram_wmask0(wm_b),
        .ram_addr0(ma_b), .ram_dout0(md_b), .ram_din0(din_b)
    );

    // Behavioural macros: command captured mid-cycle, read data valid from then on.
    logic [31:0] mem_a [NB][256];
    logic [31:0] mem_b [NB][256];

    initial begin
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < 256; w++) begin
                mem_a[b][w] = '0;
                mem_b[b][w] = '0;
            end
        end
        for (int i = 0; i < NB*256; i++) ref_mem[i] = '0;
        din_a = '0;
        din_b = '0;
    end

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!csb_a[b]) begin
                if (!web_a) begin
                    for (int k = 0; k < 4; k++) if (wm_a[k]) mem_a[b][ma_a][8*k +: 8] = md_a[8*k +: 8];
                end else begin
                    din_a[32*b +: 32] <= mem_a[b][ma_a];
                end
            end
            if (!csb_b[b]) begin
                if (!web_b) begin
                    for (int k = 0; k < 4; k++) if (wm_b[k]) mem_b[b][ma_b][8*k +: 8] = md_b[8*k +: 8];
                end else begin
                    din_b[32*b +: 32] <= mem_b[b][ma_b];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ack_a", 32'({ack_a, err_a}), 32'd0);
        check("rst_dat_a", dat_a, 32'd0);
        check("rst_csb_a", 32'(csb_a), 32'hF);
        check("rst_ctl_a", {web_a, 19'd0, wm_a, ma_a}, 32'h8000_0000);
        check("rst_dout_a", md_a, 32'd0);
        check("rst_ack_b", 32'({ack_b, err_b}), 32'd0);
        check("rst_csb_b", 32'(csb_b), 32'hF);
        check("rst_dat_b", dat_b, 32'd0);
    endtask

    // One Wishbone access presented to both bridges; each is released on its
    // own acknowledge (or error) and the run is bounded by a cycle budget.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic        hit;
        int          idx, bank, word;
        logic [3:0]  exp_csb;
        logic [31:0] exp_dat, got_a, got_b;
        logic        exp_err, gerr_a, gerr_b;
        int          exp_la, exp_lb, lat_a, lat_b, low_a, low_b;

        hit     = (a >= BASE) && (a < BASE + 32'(NB * 256 * 4));
        idx     = hit ? int'((a - BASE) >> 2) : 0;
        bank    = idx / 256;
        word    = idx % 256;
        exp_csb = 4'hF;
        if (hit) exp_csb[bank] = 1'b0;
        exp_la  = !hit ? 1 : (w ? 2 : 2 + RW_A);
        exp_lb  = !hit ? 1 : (w ? 2 : 2 + RW_B);
        exp_err = !hit && ERR_EN;
        exp_dat = (hit && !w) ? ref_mem[idx] : ((!hit && !ERR_EN) ? 32'd0 : last_rd);
        lat_a = 0; lat_b = 0; low_a = 0; low_b = 0;
        got_a = 'x; got_b = 'x; gerr_a = 1'bx; gerr_b = 1'bx;

        @(negedge clk);
        adr = a; we = w; sel = s; wdat = d;
        cyc_a = 1'b1; stb_a = 1'b1; cyc_b = 1'b1; stb_b = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("cmd_csb_a", 32'(csb_a), 32'(exp_csb));
                check("cmd_csb_b", 32'(csb_b), 32'(exp_csb));
                if (hit) begin
                    check("cmd_web_a", 32'(web_a), 32'(!w));
                    check("cmd_wmask_a", 32'(wm_a), 32'(w ? s : 4'b0000));
                    check("cmd_addr_a", 32'(ma_a), 32'(word));
                    check("cmd_addr_b", 32'(ma_b), 32'(word));
                end
                if (hit && w) check("cmd_dout_a", md_a, d);
            end
            if (csb_a != 4'hF) low_a++;
            if (csb_b != 4'hF) low_b++;
            if (lat_a == 0 && (ack_a || err_a)) begin
                lat_a = c; got_a = dat_a; gerr_a = err_a; cyc_a = 1'b0; stb_a = 1'b0;
            end else if (lat_a != 0 && c == lat_a + 1) begin
                check("pulse_a", 32'({ack_a, err_a}), 32'd0);
            end
            if (lat_b == 0 && (ack_b || err_b)) begin
                lat_b = c; got_b = dat_b; gerr_b = err_b; cyc_b = 1'b0; stb_b = 1'b0;
            end else if (lat_b != 0 && c == lat_b + 1) begin
                check("pulse_b", 32'({ack_b, err_b}), 32'd0);
            end
        end
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;

        check("lat_a", 32'(lat_a), 32'(exp_la));
        check("lat_b", 32'(lat_b), 32'(exp_lb));
        check("err_a", 32'(gerr_a), 32'(exp_err));
        check("err_b", 32'(gerr_b), 32'(exp_err));
        check("dat_a", got_a, exp_dat);
        check("dat_b", got_b, exp_dat);
        check("csb_cycles_a", 32'(low_a), 32'(hit));
        check("csb_cycles_b", 32'(low_b), 32'(hit));

        if (hit && w) begin
            for (int k = 0; k < 4; k++) if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
        end
        last_rd = exp_dat;
    endtask

    initial begin
        rst = 1'b1;
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        we = 1'b0; sel = 4'h0; wdat = '0; adr = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Basic write then read back at the window base.
        xact(1'b1, BASE, 4'hF, 32'hDEAD_BEEF);
        xact(1'b0, BASE, 4'hF, 32'h0);

        // Single-byte write merges into an existing word.
        xact(1'b1, BASE + 32'h40, 4'hF, 32'h1122_3344);
        xact(1'b1, BASE + 32'h40, 4'b0010, 32'h0000_AB00);
        xact(1'b0, BASE + 32'h40, 4'hF, 32'h0);

        // Last bank, last word; other banks untouched; bank 2 last word.
        xact(1'b1, BASE + 32'hFFC, 4'hF, 32'hCAFE_F00D);
        xact(1'b0, BASE, 4'hF, 32'h0);
        xact(1'b0, BASE + 32'hBFC, 4'hF, 32'h0);
        xact(1'b0, BASE + 32'hFFC, 4'hF, 32'h0);

        // Bank seam: last word of bank 0 plus 4 is word 0 of bank 1.
        xact(1'b1, BASE + 32'h3FC, 4'hF, 32'hA5A5_0001);
        xact(1'b1, BASE + 32'h400, 4'hF, 32'h5A5A_0002);
        xact(1'b0, BASE + 32'h3FC, 4'hF, 32'h0);
        xact(1'b0, BASE + 32'h400, 4'hF, 32'h0);

        // Byte-lane address bits are ignored.
        xact(1'b0, BASE + 32'h3, 4'hF, 32'h0);

        // Write with no byte enables still cycles the macro but changes nothing.
        xact(1'b1, BASE + 32'h40, 4'h0, 32'hFFFF_FFFF);
        xact(1'b0, BASE + 32'h40, 4'hF, 32'h0);

        // Out-of-range accesses just past and just below the window.
        xact(1'b0, BASE + 32'h1000, 4'hF, 32'h0);
        xact(1'b1, BASE - 32'h4, 4'hF, 32'h1234_5678);
        xact(1'b0, BASE + 32'h44, 4'hF, 32'h0);

        // Randomized mix of reads, writes and stray addresses.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 7) == 0) ra = $urandom();
            else ra = BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
            xact(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom());
        end

        // Master abandons a read while the bridge is in WAIT.
        @(negedge clk);
        adr = BASE + 32'h10; we = 1'b0; sel = 4'hF;
        cyc_a = 1'b1; stb_a = 1'b1; cyc_b = 1'b1; stb_b = 1'b1;
        repeat (2) @(negedge clk);
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            @(negedge clk);
            check("abort_ack_a", 32'({ack_a, err_a, csb_a}), 32'h0F);
            check("abort_ack_b", 32'({ack_b, err_b, csb_b}), 32'h0F);
        end
        xact(1'b0, BASE + 32'h10, 4'hF, 32'h0);

        // Reset while the write command is on the macro: outputs clear at once,
        // the write itself still lands.
        @(negedge clk);
        adr = BASE + 32'h804; we = 1'b1; sel = 4'hF; wdat = 32'h5A5A_1234;
        cyc_a = 1'b1; stb_a = 1'b1; cyc_b = 1'b1; stb_b = 1'b1;
        @(negedge clk);
        check("rst_cmd_csb_a", 32'(csb_a), 32'hB);
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_mem[(32'h804) >> 2] = 32'h5A5A_1234;
        last_rd = '0;
        xact(1'b0, BASE + 32'h804, 4'hF, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
